// File: rtl/bus_arb_2to1.sv
// Two-master to one-slave arbiter for the req/ack/resp memory bus.
// Grants and acks are combinational; an in-order tag FIFO steers read responses back to their masters.
module bus_arb_2to1 #(
  parameter int    RESP_DEPTH = 4,
  parameter string PRIO_MODE  = "RR"
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_addr_bi,
  input  logic [3:0]  m0_be_bi,
  input  logic [31:0] m0_wdata_bi,
  output logic        m0_ack_o,
  output logic        m0_resp_o,
  output logic [31:0] m0_rdata_bo,
  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_addr_bi,
  input  logic [3:0]  m1_be_bi,
  input  logic [31:0] m1_wdata_bi,
  output logic        m1_ack_o,
  output logic        m1_resp_o,
  output logic [31:0] m1_rdata_bo,
  output logic        s_req_o,
  output logic        s_we_o,
  output logic [31:0] s_addr_bo,
  output logic [3:0]  s_be_bo,
  output logic [31:0] s_wdata_bo,
  input  logic        s_ack_i,
  input  logic        s_resp_i,
  input  logic [31:0] s_rdata_bi
);

  localparam int PTR_W      = $clog2(RESP_DEPTH);
  localparam int CNT_W      = PTR_W + 1;
  localparam bit FIXED_PRIO = (PRIO_MODE == "FIXED");

  typedef enum logic {PRI_M0 = 1'b0, PRI_M1 = 1'b1} prio_e;

  prio_e                 prio_q, prio_d;
  logic [RESP_DEPTH-1:0] tag_q;
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q;

  logic fifo_full, fifo_empty;
  logic elig0, elig1, gnt0, gnt1;
  logic accept, push, pop, head_tag;

  assign fifo_full  = (count_q == CNT_W'(RESP_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign head_tag   = tag_q[rd_ptr_q];

  // Handshake: a transfer happens in the cycle where req and ack are both high;
  // a master keeps req and its payload stable until it sees ack. Nothing is granted while rst_i is high.
  always_comb begin
    elig0 = !rst_i && m0_req_i && (m0_we_i || !fifo_full);
    elig1 = !rst_i && m1_req_i && (m1_we_i || !fifo_full);
    gnt0  = 1'b0;
    gnt1  = 1'b0;
    if (FIXED_PRIO || prio_q == PRI_M0) begin
      gnt0 = elig0;
      gnt1 = elig1 && !elig0;
    end else begin
      gnt1 = elig1;
      gnt0 = elig0 && !elig1;
    end
  end

  assign s_req_o    = gnt0 | gnt1;
  assign s_we_o     = (gnt0 & m0_we_i) | (gnt1 & m1_we_i);
  assign s_addr_bo  = ({32{gnt0}} & m0_addr_bi)  | ({32{gnt1}} & m1_addr_bi);
  assign s_be_bo    = ({4{gnt0}}  & m0_be_bi)    | ({4{gnt1}}  & m1_be_bi);
  assign s_wdata_bo = ({32{gnt0}} & m0_wdata_bi) | ({32{gnt1}} & m1_wdata_bi);

  assign m0_ack_o = s_ack_i & gnt0;
  assign m1_ack_o = s_ack_i & gnt1;

  assign accept = s_ack_i & s_req_o;
  assign push   = accept & !s_we_o;
  // A response with no outstanding tag is an orphan and never pops.
  assign pop    = s_resp_i & !fifo_empty;

  assign m0_resp_o   = pop & !head_tag;
  assign m1_resp_o   = pop & head_tag;
  assign m0_rdata_bo = s_rdata_bi;
  assign m1_rdata_bo = s_rdata_bi;

  // The loser of an accepted transfer gets priority next time.
  always_comb begin
    prio_d = prio_q;
    if (accept) prio_d = gnt0 ? PRI_M1 : PRI_M0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prio_q <= PRI_M0;
    end else begin
      prio_q <= prio_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tag_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        tag_q[wr_ptr_q] <= gnt1;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arb_2to1.sv
// Directed bench for bus_arb_2to1: a round-robin instance and a fixed-priority
// instance share one set of inputs; expected values are written by hand.
module tb_bus_arb_2to1;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        m0_req_i, m0_we_i, m1_req_i, m1_we_i;
  logic [31:0] m0_addr_bi, m0_wdata_bi, m1_addr_bi, m1_wdata_bi;
  logic [3:0]  m0_be_bi, m1_be_bi;
  logic        s_ack_i, s_resp_i;
  logic [31:0] s_rdata_bi;

  logic        m0_ack, m0_resp, m1_ack, m1_resp, s_req, s_we;
  logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
  logic [3:0]  s_be;
  logic        fx_m0_ack, fx_m0_resp, fx_m1_ack, fx_m1_resp, fx_s_req, fx_s_we;
  logic [31:0] fx_m0_rdata, fx_m1_rdata, fx_s_addr, fx_s_wdata;
  logic [3:0]  fx_s_be;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk_i = ~clk_i;

  bus_arb_2to1 #(.RESP_DEPTH(4), .PRIO_MODE("RR")) dut_rr (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_bi(m0_addr_bi), .m0_be_bi(m0_be_bi),
    .m0_wdata_bi(m0_wdata_bi), .m0_ack_o(m0_ack), .m0_resp_o(m0_resp), .m0_rdata_bo(m0_rdata),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_bi(m1_addr_bi), .m1_be_bi(m1_be_bi),
    .m1_wdata_bi(m1_wdata_bi), .m1_ack_o(m1_ack), .m1_resp_o(m1_resp), .m1_rdata_bo(m1_rdata),
    .s_req_o(s_req), .s_we_o(s_we), .s_addr_bo(s_addr), .s_be_bo(s_be), .s_wdata_bo(s_wdata),
    .s_ack_i(s_ack_i), .s_resp_i(s_resp_i), .s_rdata_bi(s_rdata_bi)
  );

  bus_arb_2to1 #(.RESP_DEPTH(4), .PRIO_MODE("FIXED")) dut_fx (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_bi(m0_addr_bi), .m0_be_bi(m0_be_bi),
    .m0_wdata_bi(m0_wdata_bi), .m0_ack_o(fx_m0_ack), .m0_resp_o(fx_m0_resp), .m0_rdata_bo(fx_m0_rdata),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_bi(m1_addr_bi), .m1_be_bi(m1_be_bi),
    .m1_wdata_bi(m1_wdata_bi), .m1_ack_o(fx_m1_ack), .m1_resp_o(fx_m1_resp), .m1_rdata_bo(fx_m1_rdata),
    .s_req_o(fx_s_req), .s_we_o(fx_s_we), .s_addr_bo(fx_s_addr), .s_be_bo(fx_s_be), .s_wdata_bo(fx_s_wdata),
    .s_ack_i(s_ack_i), .s_resp_i(s_resp_i), .s_rdata_bi(s_rdata_bi)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    m0_req_i = 0; m0_we_i = 0; m0_addr_bi = 32'h100; m0_be_bi = 4'hF; m0_wdata_bi = 32'h0;
    m1_req_i = 0; m1_we_i = 0; m1_addr_bi = 32'h200; m1_be_bi = 4'h3; m1_wdata_bi = 32'h0;
    s_ack_i = 0; s_resp_i = 0; s_rdata_bi = 32'h0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_i = 1;
    tick();
    rst_i = 0;
  endtask

  initial begin
    rst_i = 1;
    clear_inputs();
    m0_addr_bi = 0; m0_be_bi = 0; m1_addr_bi = 0; m1_be_bi = 0;
    #1;
    check("rst_s_req", 32'(s_req), 0);
    check("rst_s_addr", s_addr, 0);
    check("rst_s_be", 32'(s_be), 0);
    check("rst_acks", 32'({m0_ack, m1_ack, fx_m0_ack, fx_m1_ack}), 0);
    check("rst_resps", 32'({m0_resp, m1_resp, fx_m0_resp, fx_m1_resp}), 0);
    check("rst_rdata", m0_rdata | m1_rdata, 0);
    tick();
    rst_i = 0;

    // Single master read, response two cycles after the request.
    clear_inputs();
    m0_req_i = 1; m0_addr_bi = 32'h10; s_ack_i = 1;
    #1;
    check("single_m0_ack", 32'(m0_ack), 1);
    check("single_s_addr", s_addr, 32'h10);
    check("single_m1_ack", 32'(m1_ack), 0);
    tick();
    m0_req_i = 0; s_ack_i = 0;
    tick();
    s_resp_i = 1; s_rdata_bi = 32'hDEADBEEF;
    #1;
    check("single_m0_resp", 32'(m0_resp), 1);
    check("single_m0_rdata", m0_rdata, 32'hDEADBEEF);
    check("single_m1_resp", 32'(m1_resp), 0);
    tick();

    // RR contention; the FIXED instance sees the same traffic.
    do_reset();
    m0_req_i = 1; m1_req_i = 1; s_ack_i = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("rr_m0_ack%0d", i), 32'(m0_ack), (i % 2 == 0) ? 1 : 0);
      check($sformatf("rr_m1_ack%0d", i), 32'(m1_ack), (i % 2 == 1) ? 1 : 0);
      check($sformatf("rr_s_addr%0d", i), s_addr, (i % 2 == 0) ? 32'h100 : 32'h200);
      check($sformatf("fx_m0_ack%0d", i), 32'(fx_m0_ack), 1);
      check($sformatf("fx_m1_ack%0d", i), 32'(fx_m1_ack), 0);
      tick();
    end
    m0_req_i = 0; m1_req_i = 0; s_ack_i = 0;
    for (int i = 0; i < 4; i++) begin
      s_resp_i = 1; s_rdata_bi = 32'hA + 32'(i);
      #1;
      check($sformatf("rr_m0_resp%0d", i), 32'(m0_resp), (i % 2 == 0) ? 1 : 0);
      check($sformatf("rr_m1_resp%0d", i), 32'(m1_resp), (i % 2 == 1) ? 1 : 0);
      check($sformatf("rr_rdata%0d", i), (i % 2 == 0) ? m0_rdata : m1_rdata, 32'hA + 32'(i));
      tick();
    end
    s_resp_i = 0;

    // FIFO full: the 5th read waits, a write still passes, one pop reopens it a cycle later.
    do_reset();
    m0_req_i = 1; s_ack_i = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("full_fill_ack%0d", i), 32'(m0_ack), 1);
      tick();
    end
    #1;
    check("full_s_req", 32'(s_req), 0);
    check("full_m0_ack", 32'(m0_ack), 0);
    tick();
    m1_req_i = 1; m1_we_i = 1; m1_wdata_bi = 32'h1234_5678;
    #1;
    check("full_wr_m1_ack", 32'(m1_ack), 1);
    check("full_wr_m0_ack", 32'(m0_ack), 0);
    check("full_wr_s_we", 32'(s_we), 1);
    check("full_wr_s_wdata", s_wdata, 32'h1234_5678);
    tick();
    m1_req_i = 0; m1_we_i = 0; s_resp_i = 1; s_rdata_bi = 32'h77;
    #1;
    check("full_pop_m0_ack", 32'(m0_ack), 0);
    check("full_pop_m0_resp", 32'(m0_resp), 1);
    tick();
    s_resp_i = 0;
    #1;
    check("full_after_pop_ack", 32'(m0_ack), 1);
    tick();

    // Slave stall, then four accepts; a 5th read must see a full FIFO.
    do_reset();
    m0_req_i = 1; m1_req_i = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("stall_s_req%0d", i), 32'(s_req), 1);
      check($sformatf("stall_s_addr%0d", i), s_addr, 32'h100);
      check($sformatf("stall_m0_ack%0d", i), 32'(m0_ack), 0);
      tick();
    end
    s_ack_i = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("stall_go_addr%0d", i), s_addr, (i % 2 == 0) ? 32'h100 : 32'h200);
      check($sformatf("stall_go_ack%0d", i), 32'({m1_ack, m0_ack}), (i % 2 == 0) ? 1 : 2);
      tick();
    end
    #1;
    check("stall_full_s_req", 32'(s_req), 0);
    tick();

    // Async reset between edges with two reads outstanding.
    do_reset();
    m0_req_i = 1; s_ack_i = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      check($sformatf("ar_ack%0d", i), 32'(m0_ack), 1);
      tick();
    end
    #2;
    check("ar_pre_s_req", 32'(s_req), 1);
    rst_i = 1;
    #1;
    check("ar_s_req", 32'(s_req), 0);
    check("ar_m0_ack", 32'(m0_ack), 0);
    check("ar_s_addr", s_addr, 0);
    clear_inputs();
    tick();
    rst_i = 0;
    s_resp_i = 1; s_rdata_bi = 32'h55;
    #1;
    check("ar_orphan_resp", 32'({m1_resp, m0_resp}), 0);
    tick();
    s_resp_i = 0;
    m1_req_i = 1; s_ack_i = 1;
    #1;
    check("ar_post_m1_ack", 32'(m1_ack), 1);
    tick();
    m1_req_i = 0; s_ack_i = 0; s_resp_i = 1; s_rdata_bi = 32'h66;
    #1;
    check("ar_post_resp", 32'({m1_resp, m0_resp}), 2);
    check("ar_post_rdata", m1_rdata, 32'h66);
    tick();
    s_resp_i = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bus_arb_2to1.md
# bus_arb_2to1

Two-master to one-slave arbiter for the req/ack/resp memory bus. It sits directly upstream of a dual-port RAM wrapper port, so an instruction fetch unit and a data/debug master can share one RAM port. Arbitration and acknowledge forwarding are combinational, which adds zero cycles to the request path. A registered in-order tag FIFO routes each read response back to the master that issued it.

## Interface
Parameters:
- RESP_DEPTH, 4: maximum number of outstanding reads. Power of two, ≥2.
- PRIO_MODE, "RR": "RR" selects round-robin. "FIXED" gives master 0 absolute priority.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge
- rst_i  in  1  reset, asynchronous, active-high
- m0_req_i, m0_we_i  in  1  master 0 request / write enable
- m0_addr_bi  in  32  master 0 byte address
- m0_be_bi  in  4  master 0 byte enables
- m0_wdata_bi  in  32  master 0 write data
- m0_ack_o  out  1  master 0 request accepted this cycle
- m0_resp_o  out  1  master 0 read data valid
- m0_rdata_bo  out  32  master 0 read data
- m1_*  (same set as m0_*, for master 1)
- s_req_o, s_we_o  out  1  slave request / write enable
- s_addr_bo  out  32  slave address
- s_be_bo  out  4  slave byte enables
- s_wdata_bo  out  32  slave write data
- s_ack_i  in  1  slave accepted the request
- s_resp_i  in  1  slave read data valid
- s_rdata_bi  in  32  slave read data

## Operation
- A transaction is accepted in any cycle where req and ack are both high. Writes produce no response. Each accepted read produces exactly one resp, and responses return in order.
- Eligibility: master n is eligible when mn_req_i=1, unless mn_we_i=0 and the tag FIFO is full.
- Grant selection (combinational):
  - "FIXED": lowest eligible index wins.
  - "RR": the eligible master matching the priority pointer wins; otherwise the other eligible master wins.
- With a grant, s_req_o=1 and s_we/addr/be/wdata mux from the granted master. With no grant, s_req_o=0 and s_* data outputs are 0.
- Acknowledge: mn_ack_o = s_ack_i & grant_n. The ungranted master's ack is 0.
- Priority pointer ("RR" only): on an accepted transaction, the pointer moves to the master that did not win. It holds otherwise.
- Tag FIFO:
  - On an accepted read, push the granted index.
  - On s_resp_i=1, pop the head.
  - Push and pop in the same cycle are both performed; count is unchanged.
  - Full/empty are decided from the registered count only, so there is no s_resp_i→ack path. When full, a pop in the same cycle does not unblock a read.
- Response routing: mn_resp_o = s_resp_i & !empty & (head == n).
- Read data: m0_rdata_bo and m1_rdata_bo both equal s_rdata_bi unconditionally. Consumers qualify it with resp.
- Orphan response: s_resp_i=1 while the FIFO is empty is dropped. No mn_resp_o is asserted and state is unchanged.
- Write requests are never blocked by FIFO state.

## Timing
- Request path: zero added latency. m*_req → s_req_o and s_ack_i → m*_ack_o are purely combinational.
- Response path: zero added latency. s_resp_i → mn_resp_o is combinational through the registered FIFO head.
- Register updates (priority pointer, FIFO pointers, count) take effect on the next clock edge.
- Reset, applied asynchronously:
  - FIFO empty, count=0.
  - Priority pointer = master 0.
  - With all inputs low, every output is 0.
- Reset mid-operation discards outstanding tags. Slave responses arriving after reset are orphans and are dropped.
- Throughput: one accepted transaction per cycle when the slave acks continuously. Under "RR" with both masters requesting every cycle, grants alternate each accepted cycle.
- A master whose request is not acked holds its request. The arbiter may still re-grant, because the pointer moves only on acceptance.

## Test plan
- Single master read: m0 reads addr 0x10; slave acks and returns resp two cycles later with 0xDEADBEEF. Required: m0_ack_o=1 in the request cycle, then m0_resp_o=1 with m0_rdata_bo=0xDEADBEEF, and m1_resp_o=0.
- RR contention: both masters read continuously, slave always acks. Required grant sequence 0,1,0,1. Responses 0xA,0xB,0xC,0xD route to m0,m1,m0,m1 in order.
- FIXED mode, both masters requesting every cycle: m0 is granted every cycle and m1_ack_o stays 0.
- FIFO full, RESP_DEPTH=4, no slave resp:
  - After 4 accepted m0 reads, a 5th m0 read sees s_req_o=0.
  - In the same cycle, an m1 write is granted and acked.
  - After one s_resp_i, the 5th read is acked on the following cycle.
- Slave stall: s_ack_i=0 for 3 cycles with both masters requesting in "RR". Required: pointer unchanged, the same master stays granted, and no FIFO push occurs.
- Async reset with 2 reads outstanding: assert rst_i between clock edges. Required: outputs go 0 immediately. After release, an s_resp_i pulse asserts neither m0_resp_o nor m1_resp_o.
